// File: rtl/dbus_pkg.sv
// Shared widths, defaults and the address-field helper for the data-bus decoder.
package dbus_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MASK_W    = 4;
  localparam int ERR_CNT_W = 16;

  // Read data returned for an access whose slave index has no port behind it.
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Extracts the w-bit slave index starting at bit lsb, zero-extended to the
  // full address width so callers can range-check it without width tricks.
  function automatic logic [ADDR_W-1:0] slave_index(
    input logic [ADDR_W-1:0] addr,
    input int unsigned       lsb,
    input int unsigned       w
  );
    logic [ADDR_W-1:0] field_mask;
    field_mask = (ADDR_W'(1) << w) - ADDR_W'(1);
    return (addr >> lsb) & field_mask;
  endfunction

endpackage

// File: rtl/dbus_slave_port.sv
// One slave-facing port: forwards the request either straight through or via a
// one-cycle input register, and owns that slave's chip select and payload.
module dbus_slave_port
  import dbus_pkg::*;
#(
  parameter bit REGISTERED = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              hit_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [MASK_W-1:0] wmask_i,
  input  logic              wen_i,
  output logic              csb_o,
  output logic              wen_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [MASK_W-1:0] wmask_o
);

  if (REGISTERED) begin : g_reg

    logic              hit_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    // Capture the select; cleared by reset so a pending request is dropped.
    // NOTE: state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        hit_q <= 1'b0;
      end else begin
        hit_q <= hit_i;
      end
    end

    // Capture the payload only when this slave is addressed.
    // NOTE: payload flops have no reset; csb gates them, so their value is
    // irrelevant until hit_q is set.
    always_ff @(posedge clk_i) begin
      if (hit_i) begin
        wen_q   <= wen_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        wmask_q <= wmask_i;
      end
    end

    // csb depends only on a flop and reset, so it cannot glitch with the
    // master-side inputs; reset forces it high without waiting for a clock.
    assign csb_o   = ~(hit_q & reset_i);
    assign wen_o   = wen_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign wmask_o = wmask_q;

  end else begin : g_direct

    // The direct path is purely combinational; the clock is not needed.
    logic unused_clk;
    assign unused_clk = clk_i;

    assign csb_o   = ~(hit_i & reset_i);
    assign wen_o   = wen_i;
    assign addr_o  = addr_i;
    assign wdata_o = wdata_i;
    assign wmask_o = wmask_i;

  end

endmodule

// File: rtl/dbus_decoder.sv
// Data-bus decoder: maps the core's data port onto NUM_SLAVES memory-mapped
// slaves by an address index field, returns read data one cycle later and
// flags accesses to unmapped indices with an error pulse and a counter.
module dbus_decoder
  import dbus_pkg::*;
#(
  parameter int unsigned       NUM_SLAVES = 4,   // must not exceed 2**SEL_W
  parameter int unsigned       SEL_LSB    = 11,
  parameter int unsigned       SEL_W      = 2,
  parameter logic [31:0]       REG_MASK   = 32'b0010,
  parameter logic [DATA_W-1:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           m_req_i,
  input  logic [ADDR_W-1:0]              m_addr_i,
  input  logic [DATA_W-1:0]              m_wdata_i,
  input  logic [MASK_W-1:0]              m_wmask_i,
  input  logic                           m_wen_i,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic                           m_err_o,
  output logic [ERR_CNT_W-1:0]           err_count_o,
  output logic [NUM_SLAVES-1:0]          s_csb_o,
  output logic [NUM_SLAVES-1:0]          s_wen_o,
  output logic [NUM_SLAVES*ADDR_W-1:0]   s_addr_o,
  output logic [NUM_SLAVES*DATA_W-1:0]   s_wdata_o,
  output logic [NUM_SLAVES*MASK_W-1:0]   s_wmask_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]   s_rdata_i
);

  logic [ADDR_W-1:0]     index;
  logic                  mapped;
  logic                  req_live;
  logic [NUM_SLAVES-1:0] hit;

  logic [SEL_W-1:0]      sel_d,  sel_q;
  logic                  valid_d, valid_q;
  logic                  err_d,  err_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d, err_cnt_q;

  // Index is kept at full address width so the range check below stays
  // meaningful even when NUM_SLAVES fills the whole index space.
  assign index    = slave_index(m_addr_i, SEL_LSB, SEL_W);
  assign mapped   = (index < ADDR_W'(NUM_SLAVES));
  assign req_live = m_req_i & reset_i;

  // One-hot slave decode for the current request.
  // NOTE: defaulting hit before the loop keeps this block free of latches.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      hit[k] = req_live & (index == ADDR_W'(k));
    end
  end

  assign sel_d   = index[SEL_W-1:0];
  assign valid_d = req_live;
  assign err_d   = req_live & ~mapped;

  // The error count saturates instead of wrapping so it never under-reports.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Response pipeline state: which slave answers next cycle, and whether the
  // previous cycle carried a request or an unmapped access.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sel_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Read return mux steered by the registered selection; both direct and
  // registered slaves present their data in the cycle after the request.
  always_comb begin
    m_rdata_o = '0;
    if (err_q) begin
      m_rdata_o = ERR_DATA;
    end else if (valid_q) begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (sel_q == SEL_W'(k)) begin
          m_rdata_o = s_rdata_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign m_err_o     = err_q;
  assign err_count_o = err_cnt_q;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_port
    dbus_slave_port #(
      .REGISTERED (REG_MASK[k])
    ) u_port (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .hit_i   (hit[k]),
      .addr_i  (m_addr_i),
      .wdata_i (m_wdata_i),
      .wmask_i (m_wmask_i),
      .wen_i   (m_wen_i),
      .csb_o   (s_csb_o[k]),
      .wen_o   (s_wen_o[k]),
      .addr_o  (s_addr_o[k*ADDR_W +: ADDR_W]),
      .wdata_o (s_wdata_o[k*DATA_W +: DATA_W]),
      .wmask_o (s_wmask_o[k*MASK_W +: MASK_W])
    );
  end

endmodule

// File: tb/tb_dbus_decoder.sv
// Scoreboard bench for dbus_decoder with three slaves: slave 0 and 2 direct
// (synchronous-read RAMs), slave 1 registered (combinational-read RAM);
// index 3 is unmapped.
module tb_dbus_decoder;

  localparam int NS = 3;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            m_req_i;
  logic [31:0]     m_addr_i;
  logic [31:0]     m_wdata_i;
  logic [3:0]      m_wmask_i;
  logic            m_wen_i;
  logic [31:0]     m_rdata_o;
  logic            m_err_o;
  logic [15:0]     err_count_o;
  logic [NS-1:0]   s_csb_o;
  logic [NS-1:0]   s_wen_o;
  logic [NS*32-1:0] s_addr_o;
  logic [NS*32-1:0] s_wdata_o;
  logic [NS*4-1:0]  s_wmask_o;
  logic [NS*32-1:0] s_rdata_i;

  dbus_decoder #(
    .NUM_SLAVES (NS),
    .SEL_LSB    (11),
    .SEL_W      (2),
    .REG_MASK   (32'b0010),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .m_req_i     (m_req_i),
    .m_addr_i    (m_addr_i),
    .m_wdata_i   (m_wdata_i),
    .m_wmask_i   (m_wmask_i),
    .m_wen_i     (m_wen_i),
    .m_rdata_o   (m_rdata_o),
    .m_err_o     (m_err_o),
    .err_count_o (err_count_o),
    .s_csb_o     (s_csb_o),
    .s_wen_o     (s_wen_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_wmask_o   (s_wmask_o),
    .s_rdata_i   (s_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- slave models ----------------
  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  logic [31:0] mem2 [0:255];
  logic [31:0] rd0, rd2;
  int          wr_cnt1 = 0;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign s_rdata_i = {rd2, mem1[s_addr_o[32+2 +: 8]], rd0};

  always @(posedge clk_i) begin
    if (!s_csb_o[0]) begin
      rd0 <= mem0[s_addr_o[2 +: 8]];
      if (!s_wen_o[0])
        mem0[s_addr_o[2 +: 8]] <= merge(mem0[s_addr_o[2 +: 8]], s_wdata_o[31:0], s_wmask_o[3:0]);
    end
    if (!s_csb_o[1] && !s_wen_o[1]) begin
      mem1[s_addr_o[34 +: 8]] <= merge(mem1[s_addr_o[34 +: 8]], s_wdata_o[63:32], s_wmask_o[7:4]);
      wr_cnt1 <= wr_cnt1 + 1;
    end
    if (!s_csb_o[2]) begin
      rd2 <= mem2[s_addr_o[66 +: 8]];
      if (!s_wen_o[2])
        mem2[s_addr_o[66 +: 8]] <= merge(mem2[s_addr_o[66 +: 8]], s_wdata_o[95:64], s_wmask_o[11:8]);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_cnt = 16'h0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response is due exactly one cycle after its request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due < cyc) begin
          n_vec++;
          n_bad++;
          $display("FAIL stale: response due cycle %0d, now %0d", e.due, cyc);
        end else begin
          check("rdata", m_rdata_o, e.rdata);
          check("err", 32'(m_err_o), 32'(e.err));
          check("cnt", 32'(err_count_o), 32'(e.cnt));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic wen);
    @(posedge clk_i);
    #1;
    m_req_i   = req;
    m_addr_i  = addr;
    m_wdata_i = wdata;
    m_wmask_i = wmask;
    m_wen_i   = wen;
  endtask

  task automatic issue(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic wen,
                       input logic [31:0] exp_rdata, input logic exp_err);
    drive(req, addr, wdata, wmask, wen);
    if (exp_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    sb_q.push_back('{due: cyc + 1, rdata: exp_rdata, err: exp_err, cnt: exp_cnt});
  endtask

  task automatic idle();
    issue(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);
  endtask

  int wr1_before;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'hA000_0000 + i;
      mem1[i] = 32'hB000_0000 + i;
      mem2[i] = 32'hC000_0000 + i;
    end
    mem0[4] = 32'h1234_5678;

    // Reset held with a live request to slave 0.
    reset_i = 1'b1; m_req_i = 1'b1; m_addr_i = 32'h0;
    m_wdata_i = 32'h0; m_wmask_i = 4'h0; m_wen_i = 1'b1;
    #1 reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_csb", 32'(s_csb_o), 32'b111);
    check("reset_rdata", m_rdata_o, 32'h0);
    check("reset_err", 32'(m_err_o), 32'h0);
    check("reset_cnt", 32'(err_count_o), 32'h0);
    @(posedge clk_i); #1;
    reset_i = 1'b1; m_req_i = 1'b0;

    // Direct read of slave 0.
    issue(1'b1, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 1'b0);
    @(negedge clk_i);
    check("dread_csb_n", 32'(s_csb_o), 32'b110);
    check("dread_addr0", s_addr_o[31:0], 32'h10);
    idle();
    @(negedge clk_i);
    check("dread_csb_n1", 32'(s_csb_o), 32'b111);

    // Registered write to slave 1: visible on the slave only in N+1.
    issue(1'b1, 32'h0000_0804, 32'hA5A5_0001, 4'b1111, 1'b0, 32'hB000_0001, 1'b0);
    @(negedge clk_i);
    check("rwr_csb_n", 32'(s_csb_o), 32'b111);
    idle();
    @(negedge clk_i);
    check("rwr_csb_n1", 32'(s_csb_o), 32'b101);
    check("rwr_wen1", 32'(s_wen_o[1]), 32'h0);
    check("rwr_addr1", s_addr_o[63:32], 32'h804);
    check("rwr_wdata1", s_wdata_o[63:32], 32'hA5A5_0001);
    check("rwr_wmask1", 32'(s_wmask_o[7:4]), 32'hF);
    idle();
    @(negedge clk_i);
    check("rwr_csb_n2", 32'(s_csb_o), 32'b111);
    issue(1'b1, 32'h0000_0804, 32'h0, 4'h0, 1'b1, 32'hA5A5_0001, 1'b0);
    idle();

    // Read-after-write on consecutive requests, partial byte mask.
    issue(1'b1, 32'h0000_0808, 32'h1122_3344, 4'b0011, 1'b0, 32'hB000_0002, 1'b0);
    issue(1'b1, 32'h0000_0808, 32'h0, 4'h0, 1'b1, 32'hB000_3344, 1'b0);
    idle();

    // Back-to-back: registered slave 1 then direct slave 0.
    issue(1'b1, 32'h0000_0800, 32'h0, 4'h0, 1'b1, 32'hB000_0000, 1'b0);
    issue(1'b1, 32'h0000_0000, 32'h0, 4'h0, 1'b1, 32'hA000_0000, 1'b0);
    @(negedge clk_i);
    check("b2b_csb", 32'(s_csb_o), 32'b100);
    idle();

    // Direct write then read of slave 2.
    issue(1'b1, 32'h0000_1008, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'hC000_0002, 1'b0);
    @(negedge clk_i);
    check("dwr_csb", 32'(s_csb_o), 32'b011);
    check("dwr_wen2", 32'(s_wen_o[2]), 32'h0);
    check("dwr_wdata2", s_wdata_o[95:64], 32'h0BAD_F00D);
    issue(1'b1, 32'h0000_1008, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D, 1'b0);
    idle();

    // Unmapped read and write.
    issue(1'b1, 32'h0000_1800, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk_i);
    check("unm_csb_rd", 32'(s_csb_o), 32'b111);
    issue(1'b1, 32'h0000_1804, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk_i);
    check("unm_csb_wr", 32'(s_csb_o), 32'b111);
    idle();
    idle();

    // Drive the counter past saturation: 2 + 65534 = 65536 errors in total.
    for (int i = 0; i < 65534; i++) begin
      issue(1'b1, 32'h0000_1800 + 32'((i % 4) * 4), 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    end
    idle();
    @(negedge clk_i);
    check("sat_cnt", 32'(err_count_o), 32'hFFFF);
    idle();

    // Reset falls while a registered write is pending.
    @(negedge clk_i);
    wr1_before = wr_cnt1;
    drive(1'b1, 32'h0000_0800, 32'h5555_AAAA, 4'b1111, 1'b0);
    @(negedge clk_i);
    check("rstmid_csb_n", 32'(s_csb_o), 32'b111);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_csb_n1", 32'(s_csb_o), 32'b111);
    check("rstmid_rdata", m_rdata_o, 32'h0);
    check("rstmid_err", 32'(m_err_o), 32'h0);
    check("rstmid_cnt", 32'(err_count_o), 32'h0);
    @(posedge clk_i); #1;
    reset_i = 1'b1; m_req_i = 1'b0;
    exp_cnt = 16'h0;
    idle();
    @(negedge clk_i);
    check("rstmid_nowrite", 32'(wr_cnt1 - wr1_before), 32'h0);
    issue(1'b1, 32'h0000_0800, 32'h0, 4'h0, 1'b1, 32'hB000_0000, 1'b0);
    idle();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk_i);
    @(negedge clk_i);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d responses never checked, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_decoder.md
Name: dbus_decoder

Overview:
- Parametrised data-bus decoder between the core's data port and N memory-mapped slaves (SRAM, mtime registers, future peripherals).
- Decodes a slave index field of the address and drives per-slave active-low chip selects.
- Per slave, forwards request signals either directly or through a one-cycle input register.
- Returns read data through a mux steered by the registered selection.
- Adds unmapped-address error signalling and a saturating error counter.

Parameters:
NUM_SLAVES, 4, number of slave ports; must satisfy NUM_SLAVES <= 2**SEL_W
SEL_LSB, 11, lowest address bit of the slave index field
SEL_W, 2, width of the slave index field; index = m_addr_i[SEL_LSB+SEL_W-1:SEL_LSB]
REG_MASK, 4'b0010, bit k=1: slave k receives its request signals registered by one cycle
ERR_DATA, 32'hDEAD_BEEF, read data returned for unmapped accesses

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-low
m_req_i  in  1  master access valid this cycle
m_addr_i  in  32  master byte address
m_wdata_i  in  32  master write data
m_wmask_i  in  4  byte write mask
m_wen_i  in  1  write enable, active-low (1 = read)
m_rdata_o  out  32  read data, valid one cycle after the request
m_err_o  out  1  one-cycle pulse, aligned with m_rdata_o, for an unmapped access
err_count_o  out  16  saturating count of unmapped accesses
s_csb_o  out  NUM_SLAVES  per-slave chip select, active-low
s_wen_o  out  NUM_SLAVES  per-slave write enable, active-low
s_addr_o  out  NUM_SLAVES*32  per-slave address, slice k = slave k
s_wdata_o  out  NUM_SLAVES*32  per-slave write data
s_wmask_o  out  NUM_SLAVES*4  per-slave byte mask
s_rdata_i  in  NUM_SLAVES*32  per-slave read data

Behaviour:
- Decode (cycle N): hit_k = m_req_i & (index == k) & reset_i. Index >= NUM_SLAVES with m_req_i=1 is unmapped.
- Direct slave (REG_MASK[k]=0):
  - s_csb_o[k] = !hit_k combinationally in cycle N.
  - addr, wdata, wmask and wen pass through unchanged.
  - Slave must present read data in cycle N+1 (synchronous-read SRAM model).
- Registered slave (REG_MASK[k]=1):
  - hit_k, address, wdata, wmask and wen are captured at the edge ending cycle N and driven during N+1.
  - s_csb_o[k] = !hit_q_k.
  - Slave must return read data combinationally in N+1. Its write takes effect at the edge ending N+1.
- Read return:
  - sel_q (index), valid_q and err_q are registered at the end of cycle N.
  - In cycle N+1: m_rdata_o = s_rdata_i[sel_q] if valid_q & !err_q; ERR_DATA if err_q; else 32'h0.
  - Read latency is 1 cycle for every slave.
- Pipelining:
  - A new request is accepted every cycle; there is no stall.
  - In N+1, a registered slave (from request N) and a direct slave (from request N+1) may both have csb low; this is legal.
  - Read-after-write to the same registered slave on consecutive requests returns the new data.
- Unmapped access:
  - No s_csb_o asserted; writes are discarded.
  - In N+1: m_rdata_o = ERR_DATA and m_err_o = 1 for exactly one cycle.
  - err_count_o increments by 1 and saturates at 16'hFFFF.
- m_req_i=0: no chip select asserted; in N+1 valid_q=0 and m_rdata_o=0.
- Reset:
  - While reset_i=0, all s_csb_o=1 combinationally, including registered paths.
  - All registers clear: hit_q=0, valid_q=0, err_q=0, err_count_o=0; m_rdata_o=0, m_err_o=0.
  - Reset asserted mid-pipeline drops the pending registered request; no write reaches the slave.
- Outputs of a slave whose csb is high are don't-care, but must not glitch csb.

Decomposition:
- Package dbus_pkg:
  - DATA_W=32, ADDR_W=32, MASK_W=4, ERR_CNT_W=16, default ERR_DATA.
  - Function slave_index(addr, lsb, w).
- Sub-module dbus_slave_port:
  - One per slave via generate.
  - Parameter REGISTERED selects the bypass or register path.
  - Owns the csb/wen/addr/wdata/wmask for one slave.
- Top level owns decode, sel_q/valid_q/err_q, the read mux and the error counter.

Test Plan:
- Reset: hold reset_i=0 with m_req_i=1 at addr 0x0 -> s_csb_o=4'b1111, m_rdata_o=0, m_err_o=0, err_count_o=0.
- Direct read: req at N, addr 0x0000_0010, wen=1; slave0 drives 0x1234_5678 in N+1 -> s_csb_o[0]=0 only in N, s_addr_o[0]=0x10; m_rdata_o=0x1234_5678 in N+1.
- Registered write: N, addr 0x0000_0804, wdata 0xA5A5_0001, wmask 4'b1111, wen=0 -> s_csb_o[1]=0, s_wen_o[1]=0, addr 0x804, wdata 0xA5A5_0001, all during N+1 only; nothing in N.
- Back-to-back: read 0x800 at N, read 0x000 at N+1 -> s_csb_o[1] and s_csb_o[0] both low in N+1; m_rdata_o = slave1 data in N+1, slave0 data in N+2.
- Unmapped (NUM_SLAVES=3): read 0x1800 -> no csb low, m_rdata_o=0xDEAD_BEEF and m_err_o=1 in N+1, err_count_o=1. Preload the counter to 0xFFFF via 65535 accesses -> the next error leaves it at 0xFFFF.
- Reset mid-operation: write to 0x800 at N, reset_i falls before the N/N+1 edge -> s_csb_o[1] never low; slave1 sees no write; m_rdata_o=0.
